// File: rtl/burst_memory_pkg.sv
// Shared types and helpers for the burst main-memory model.
package memory_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        SIZE_1  = 2'b00,
        SIZE_4  = 2'b01,
        SIZE_8  = 2'b10,
        SIZE_16 = 2'b11
    } access_size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Number of words moved by one request of the given size code.
    function automatic logic [4:0] burst_len(input logic [1:0] access_size);
        case (access_size)
            SIZE_1:  return 5'd1;
            SIZE_4:  return 5'd4;
            SIZE_8:  return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/burst_memory_byte_array.sv
// Byte-wide storage with one big-endian word read port and one word write port.
module mem_byte_array
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1048576,
    parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
    input  logic                  clock,
    input  logic [IDX_W-1:0]      index,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int BPW = DATA_WIDTH / 8;

    logic [7:0] mem [DEPTH_BYTES];

    // Store the word most-significant byte first at the lowest address.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < BPW; b++) begin
                mem[index + IDX_W'(b)] <= wdata[DATA_WIDTH-1-8*b -: 8];
            end
        end
    end

    // Assemble the word at index, lowest address in the top byte.
    always_comb begin
        rdata = '0;
        for (int b = 0; b < BPW; b++) begin
            rdata[DATA_WIDTH-1-8*b -: 8] = mem[index + IDX_W'(b)];
        end
    end

endmodule

// File: rtl/burst_memory.sv
// Burst main memory: request acceptance, range check, burst sequencing and
// registered read outputs around the byte array.
module burst_memory
    import memory_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);

    localparam int                    IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(BYTES_PER_WORD);

    state_t                state, state_next;
    logic [4:0]            remaining, remaining_next;
    logic [ADDR_WIDTH-1:0] pointer, pointer_next;
    logic                  dir, dir_next;
    logic [4:0]            len;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] span;
    logic                  request_bad;
    logic [IDX_W-1:0]      index;
    logic                  write_enable;
    logic                  read_beat;
    logic                  error_next;
    logic [DATA_WIDTH-1:0] rdata;

    assign len  = burst_len(access_size);
    assign base = address - START_ADDR;
    assign span = ADDR_WIDTH'({len, 2'b00});
    // Comparing against DEPTH - span keeps the check free of wrap-around.
    assign request_bad = (address[1:0] != 2'b00) || (address < START_ADDR) ||
                         (base > DEPTH_A - span);
    assign busy = (state == BURST);

    mem_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BYTES(DEPTH_BYTES),
        .IDX_W      (IDX_W)
    ) u_array (
        .clock(clock),
        .index(index),
        .wdata(data_in),
        .we   (write_enable),
        .rdata(rdata)
    );

    // Next-state, beat strobes and the word pointer for the array ports.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        pointer_next   = pointer;
        dir_next       = dir;
        index          = pointer[IDX_W-1:0];
        write_enable   = 1'b0;
        read_beat      = 1'b0;
        error_next     = 1'b0;
        case (state)
            IDLE: begin
                index = base[IDX_W-1:0];
                if (enable) begin
                    if (request_bad) begin
                        error_next = 1'b1;
                    end else begin
                        dir_next     = rw;
                        read_beat    = rw;
                        write_enable = !rw;
                        if (len != 5'd1) begin
                            state_next     = BURST;
                            remaining_next = len - 5'd1;
                            pointer_next   = base + WORD_STEP;
                        end
                    end
                end
            end
            BURST: begin
                read_beat      = dir;
                write_enable   = !dir;
                pointer_next   = pointer + WORD_STEP;
                remaining_next = remaining - 5'd1;
                if (remaining == 5'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A reset edge aborts the burst, so the beat it would perform must not land.
        if (reset) begin
            write_enable = 1'b0;
        end
    end

    // State, counters and registered read outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            pointer    <= '0;
            dir        <= 1'b0;
            data_valid <= 1'b0;
            error      <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_next;
            remaining  <= remaining_next;
            pointer    <= pointer_next;
            dir        <= dir_next;
            data_valid <= read_beat;
            error      <= error_next;
            if (read_beat) begin
                data_out <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: request table plus hand-built sequences,
// read data checked against a byte-level shadow model through a scoreboard queue.
module tb_burst_memory;

    localparam logic [31:0] START = 32'h80020000;
    localparam int          DEPTH = 1048576;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        error;

    always #5 clock = ~clock;

    burst_memory #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_BYTES(DEPTH),
        .START_ADDR (START)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .enable     (enable),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .error      (error)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expq[$];
    logic [7:0]  shadow[logic [31:0]];
    logic [31:0] wbuf[16];
    logic [31:0] mon_exp;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          err;
        bit          hold;
        logic [31:0] seed;
        logic [31:0] step;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int len_of(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (1 << (s + 1));
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            w[31-8*b -: 8] = shadow.exists(a + 32'(b)) ? shadow[a + 32'(b)] : 8'h00;
        end
        return w;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            shadow[a + 32'(b)] = w[31-8*b -: 8];
        end
    endtask

    // Called on a falling edge; returns on the first falling edge with busy low.
    task automatic run_burst(input logic r, input logic [31:0] a, input logic [1:0] sz,
                             input bit exp_err, input bit hold, input string tag);
        int n;
        int cnt;
        n   = len_of(sz);
        cnt = 0;
        enable      = 1'b1;
        rw          = r;
        address     = a;
        access_size = sz;
        data_in     = wbuf[0];
        if (r && !exp_err) begin
            for (int k = 0; k < n; k++) expq.push_back(model_word(a + 32'(4 * k)));
        end
        @(negedge clock);
        if (hold) begin
            enable      = 1'b1;
            rw          = 1'b0;
            address     = START;
            access_size = 2'b11;
        end else begin
            enable = 1'b0;
        end
        check({tag, " error"}, 32'(error), 32'(exp_err));
        check({tag, " busy after accept"}, 32'(busy), 32'(!exp_err && n > 1));
        check({tag, " valid after accept"}, 32'(data_valid), 32'(r && !exp_err));
        while (busy && cnt < 40) begin
            data_in = hold ? 32'hBADBAD00 : wbuf[(cnt + 1) % 16];
            cnt++;
            @(negedge clock);
            check({tag, " valid in burst"}, 32'(data_valid), 32'(r));
        end
        enable = 1'b0;
        check({tag, " busy cycles"}, 32'(cnt), exp_err ? 32'd0 : 32'(n - 1));
        if (exp_err) begin
            @(negedge clock);
            check({tag, " error one cycle"}, 32'(error), 32'd0);
        end
        if (!r && !exp_err) begin
            for (int k = 0; k < n; k++) model_write(a + 32'(4 * k), wbuf[k]);
        end
    endtask

    // Every read beat the DUT reports must match the next expected word.
    always @(negedge clock) begin
        if (!reset && data_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=%h required=none", data_out);
            end else begin
                mon_exp = expq.pop_front();
                check("read data", data_out, mon_exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, START,          2'b00, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, START,          2'b00, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, START + 32'h10, 2'b01, 1'b0, 1'b0, 32'h11111111, 32'h11111111};
        vecs[3]  = '{1'b1, START + 32'h10, 2'b01, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, START + 32'h120, 2'b11, 1'b0, 1'b0, 32'h5A000000, 32'h00010001};
        vecs[5]  = '{1'b0, START + 32'h100, 2'b10, 1'b0, 1'b0, 32'hA5000000, 32'h1};
        vecs[6]  = '{1'b1, START + 32'h100, 2'b11, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, START + 32'h2,  2'b00, 1'b1, 1'b0, 32'h0BADF00D, 32'h0};
        vecs[8]  = '{1'b1, 32'h8001FFFC,   2'b00, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 32'h8011FFF0,   2'b01, 1'b0, 1'b0, 32'hC0DE0000, 32'h1};
        vecs[10] = '{1'b0, 32'h8011FFF0,   2'b11, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0};
        vecs[11] = '{1'b1, 32'h8011FFF0,   2'b01, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[12] = '{1'b1, START + 32'h100, 2'b10, 1'b0, 1'b1, 32'h0,        32'h0};
        vecs[13] = '{1'b1, START,          2'b00, 1'b0, 1'b0, 32'h0,        32'h0};

        reset       = 1'b1;
        enable      = 1'b0;
        rw          = 1'b0;
        address     = '0;
        access_size = 2'b00;
        data_in     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(data_valid), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset data_out", data_out, 32'd0);

        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = vecs[i].seed + 32'(k) * vecs[i].step;
            run_burst(vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].err, vecs[i].hold,
                      $sformatf("v%0d", i));
        end
        check("byte mem0", 32'(dut.u_array.mem[0]), 32'h000000DE);

        // Reset on beat 2 of a 4-word write over a pre-filled region.
        for (int k = 0; k < 16; k++) wbuf[k] = 32'hA0A0A0A0 + 32'(k);
        run_burst(1'b0, START + 32'h200, 2'b01, 1'b0, 1'b0, "prefill");
        enable      = 1'b1;
        rw          = 1'b0;
        address     = START + 32'h200;
        access_size = 2'b01;
        data_in     = 32'hB0000000;
        @(negedge clock);
        enable  = 1'b0;
        data_in = 32'hB0000001;
        @(negedge clock);
        check("abort busy before reset", 32'(busy), 32'd1);
        data_in = 32'hB0000002;
        reset   = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort valid", 32'(data_valid), 32'd0);
        check("abort error", 32'(error), 32'd0);
        check("abort data_out", data_out, 32'd0);
        model_write(START + 32'h200, 32'hB0000000);
        model_write(START + 32'h204, 32'hB0000001);
        run_burst(1'b1, START + 32'h200, 2'b01, 1'b0, 1'b0, "after abort");

        // data_out must hold the last beat once data_valid drops.
        repeat (2) @(negedge clock);
        check("hold valid", 32'(data_valid), 32'd0);
        check("hold data_out", data_out, 32'hA0A0A0A3);
        check("scoreboard drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Byte-addressable, big-endian main memory model for the MIPS processor; successor to the single-word/4-word memory.
- Provides single-word and 4/8/16-word burst reads and writes through a registered FSM.
- Adds a proper busy handshake, a read data-valid strobe, and address/range error reporting.
- Sits between the fetch/load-store stages and the program image loaded at START_ADDR.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_BYTES, 1048576, storage size in bytes.
- START_ADDR, 32'h80020000, byte address that maps to storage index 0.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address of first word; sampled at acceptance only.
- data_in  in  DATA_WIDTH  write data; sampled on every write beat.
- access_size  in  2  00 = 1 word, 01 = 4 words, 10 = 8 words, 11 = 16 words.
- rw  in  1  1 = read, 0 = write.
- enable  in  1  request strobe.
- busy  out  1  burst in progress; new requests ignored.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  data_out holds a valid read beat.
- error  out  1  one-cycle pulse; request rejected.

Behaviour:
- Reset: busy = 0, data_valid = 0, error = 0, data_out = 0, state = IDLE, beat counter = 0. Storage contents are not cleared.
- Reset mid-burst: the burst aborts at that edge and no further beats occur. Bytes already written are retained.
- States are IDLE and BURST; busy = (state == BURST), registered.
- Acceptance: edge where state == IDLE && enable == 1. Latch rw, N = 1/4/8/16 from access_size, and base = address - START_ADDR.
- Error check at acceptance: address[1:0] != 0, or address < START_ADDR, or base + 4N > DEPTH_BYTES.
  - If it fails: error = 1 for the next cycle, no storage access, state stays IDLE.
- Beat 0 is performed on the acceptance edge. If N > 1, go to BURST with remaining = N-1 and word pointer = base + 4.
- Each BURST edge performs one beat, increments the pointer by 4, and decrements remaining. Return to IDLE on the edge that performs beat N-1.
- busy is high for exactly N-1 cycles, starting the cycle after acceptance.
- enable, address, access_size and rw are ignored while busy. Burst direction is fixed at acceptance.
- A new request may be accepted on the first cycle busy is low, i.e. the cycle after the last beat edge.
- Write beat: mem[p] <= data_in[31:24], mem[p+1] <= data_in[23:16], mem[p+2] <= data_in[15:8], mem[p+3] <= data_in[7:0].
  - The bench must present word k on the cycle preceding beat edge k.
  - data_valid stays 0 during writes.
- Read beat: data_out <= {mem[p], mem[p+1], mem[p+2], mem[p+3]}. data_valid = 1 in the cycle after each read beat edge.
  - data_valid is high for N consecutive cycles.
  - data_out holds its last value when data_valid = 0.
- Latency: 1 cycle from acceptance to the first valid read word. A 1-word write completes on the acceptance edge.
- Address arithmetic is done in ADDR_WIDTH bits. The range check prevents any wrap past DEPTH_BYTES.
- An error request and a valid request can never overlap, because only IDLE accepts.

Decomposition:
- Package memory_pkg holds:
  - the access_size encodings and the burst_len(access_size) function (returns 1/4/8/16);
  - the state enum {IDLE, BURST};
  - BYTES_PER_WORD = 4.
- Sub-module mem_byte_array: DEPTH_BYTES x 8 storage with one word-wide big-endian read port and one write port (index, wdata, we).
- burst_memory holds the FSM, counters, the range check and the output registers.

Test Plan:
- Reset, then a 1-word write of 32'hDEADBEEF at 32'h80020000, then a 1-word read there: data_valid 1 cycle after the read, data_out = 32'hDEADBEEF, busy never high. A byte read-back via the array shows mem[0] = 8'hDE.
- 4-word write of 11111111, 22222222, 33333333, 44444444 at 32'h80020010, then a 4-word read: busy high 3 cycles per burst, data_valid high 4 consecutive cycles returning the words in order.
- 16-word read issued immediately when busy drops after an 8-word write: the second request is accepted with no gap, and busy is high 15 cycles.
- Misaligned address 32'h80020002, an address below START_ADDR (32'h8001FFFC), and a 16-word burst at START_ADDR + DEPTH_BYTES - 16: each gives error = 1 for one cycle, busy = 0, and memory is unchanged.
- enable held high with a different address during an 8-word read: requests are ignored until busy = 0, and the burst data is unaffected.
- reset asserted on beat 2 of a 4-word write: busy = 0 and data_valid = 0 the next cycle, words 0-1 are retained, words 2-3 are unchanged, and the next request is accepted normally.
